// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: FSM encoding, header
// packing and the framing constants used by the source and its payload buffer.
package router_pkg;

  localparam int ADDR_W  = 2;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 63;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  // FSM encoding; kept as plain constants so existing checkers can bind to it.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_HEADER  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_PARITY  = 3'd4;

  // Header byte as the router expects it: length in the upper bits, port below.
  function automatic logic [LEN_W+ADDR_W-1:0] pack_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_src_buf.sv
// Payload store for the packet source: one synchronous write port and an
// asynchronous read port, so the byte under the read pointer is always on rdata.
module router_src_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // No reset: contents are only read after a full LOAD has rewritten them.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for the 1x3 router: buffers a payload, then emits header,
// payload and parity bytes on data_out/pkt_valid, holding each byte while busy.
module router_pkt_src #(
  parameter int MAX_LEN = 63,
  parameter int LEN_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_bad_parity,
  output logic             cmd_err,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [7:0]       pl_data,
  input  logic             busy,
  output logic [7:0]       data_out,
  output logic             pkt_valid,
  output logic             done
);

  import router_pkg::*;

  // Handshakes: a command transfers on a posedge with cmd_valid & cmd_ready,
  // a payload byte on a posedge with pl_valid & pl_ready, and an output byte
  // on a posedge where the source is in HEADER/PAYLOAD/PARITY and busy is low.

  logic [2:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic [7:0]       header;
  logic [7:0]       parity;
  logic             bad_parity;
  logic [7:0]       rd_data;

  logic             cmd_fire;
  logic             cmd_illegal;
  logic             pl_fire;
  logic             byte_taken;
  logic             last_byte;
  logic [LEN_W-1:0] len_m1;

  assign cmd_fire    = (state == ST_IDLE) && cmd_valid;
  assign cmd_illegal = (cmd_addr == ILLEGAL_ADDR) || (cmd_len == '0);
  assign pl_fire     = (state == ST_LOAD) && pl_valid;
  assign byte_taken  = !busy;
  assign len_m1      = len - {{(LEN_W-1){1'b0}}, 1'b1};
  assign last_byte   = (cnt == len_m1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len        <= '0;
      header     <= '0;
      parity     <= '0;
      bad_parity <= 1'b0;
      cmd_err    <= 1'b0;
      done       <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_illegal) begin
              cmd_err <= 1'b1;
            end else begin
              len        <= cmd_len;
              header     <= pack_header(cmd_len, cmd_addr);
              parity     <= pack_header(cmd_len, cmd_addr);
              bad_parity <= cmd_bad_parity;
              cnt        <= '0;
              state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (pl_fire) begin
            parity <= parity ^ pl_data;
            if (last_byte) begin
              cnt   <= '0;
              state <= ST_HEADER;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (byte_taken) begin
            state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (byte_taken) begin
            if (last_byte) begin
              cnt   <= '0;
              state <= ST_PARITY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (byte_taken) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  router_src_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .clock (clock),
    .we    (pl_fire),
    .waddr (cnt),
    .wdata (pl_data),
    .raddr (cnt),
    .rdata (rd_data)
  );

  // Outputs decode registered state only, so a stall simply freezes them.
  assign cmd_ready = (state == ST_IDLE);
  assign pl_ready  = (state == ST_LOAD);
  assign pkt_valid = (state == ST_HEADER) || (state == ST_PAYLOAD);

  always_comb begin
    data_out = 8'h00;
    case (state)
      ST_HEADER:  data_out = header;
      ST_PAYLOAD: data_out = rd_data;
      ST_PARITY:  data_out = bad_parity ? ~parity : parity;
      default:    data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: clean, stalled, corrupted-parity, illegal,
// gapped, back-to-back and mid-packet-reset scenarios with hand-computed bytes.
module tb_router_pkt_src;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity;
  logic       cmd_err;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       done;

  int total;
  int bad;

  logic [7:0] pay[$];

  router_pkt_src dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_bad_parity (cmd_bad_parity),
    .cmd_err        (cmd_err),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .pl_data        (pl_data),
    .busy           (busy),
    .data_out       (data_out),
    .pkt_valid      (pkt_valid),
    .done           (done)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input logic badp);
    chk("cmd_ready_before_cmd", cmd_ready, 8'h01);
    cmd_valid      = 1'b1;
    cmd_addr       = addr;
    cmd_len        = len;
    cmd_bad_parity = badp;
    tick();
    cmd_valid      = 1'b0;
    cmd_bad_parity = 1'b0;
  endtask

  task automatic load_payload();
    for (int i = 0; i < pay.size(); i++) begin
      chk("pl_ready_in_load", pl_ready, 8'h01);
      chk("pkt_valid_in_load", pkt_valid, 8'h00);
      pl_valid = 1'b1;
      pl_data  = pay[i];
      tick();
      pl_valid = 1'b0;
    end
  endtask

  // Expects to be called in the first HEADER cycle; ends one cycle after done.
  task automatic tx_check(input logic [7:0] hdr, input logic [7:0] par,
                          input int stall_idx, input int stall_n);
    busy = 1'b0;
    chk("header_byte", data_out, hdr);
    chk("header_pkt_valid", pkt_valid, 8'h01);
    chk("pl_ready_after_load", pl_ready, 8'h00);
    tick();
    for (int i = 0; i < pay.size(); i++) begin
      chk("payload_byte", data_out, pay[i]);
      chk("payload_pkt_valid", pkt_valid, 8'h01);
      if (i == stall_idx) begin
        busy = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall_held_byte", data_out, pay[i]);
          chk("stall_held_pkt_valid", pkt_valid, 8'h01);
        end
        busy = 1'b0;
      end
      tick();
    end
    chk("parity_byte", data_out, par);
    chk("parity_pkt_valid", pkt_valid, 8'h00);
    chk("done_before_parity_taken", done, 8'h00);
    tick();
    chk("done_pulse", done, 8'h01);
    chk("pkt_valid_after_parity", pkt_valid, 8'h00);
    tick();
    chk("done_single_cycle", done, 8'h00);
    chk("cmd_ready_after_done", cmd_ready, 8'h01);
  endtask

  // directed sequence
  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_addr       = 2'd0;
    cmd_len        = 6'd0;
    cmd_bad_parity = 1'b0;
    pl_valid       = 1'b0;
    pl_data        = 8'h00;
    busy           = 1'b0;

    tick();
    tick();
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_pkt_valid", pkt_valid, 8'h00);
    chk("reset_cmd_ready", cmd_ready, 8'h01);
    chk("reset_pl_ready", pl_ready, 8'h00);
    chk("reset_cmd_err", cmd_err, 8'h00);
    chk("reset_done", done, 8'h00);
    reset = 1'b0;
    tick();

    // Clean packet: addr 2, len 5 -> header 16, parity F7.
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_cmd(2'd2, 6'd5, 1'b0);
    load_payload();
    tx_check(8'h16, 8'hF7, -1, 0);

    // Same packet with a 3-cycle stall on C3.
    send_cmd(2'd2, 6'd5, 1'b0);
    load_payload();
    tx_check(8'h16, 8'hF7, 2, 3);

    // Corrupted parity: ~F7 = 08.
    send_cmd(2'd2, 6'd5, 1'b1);
    load_payload();
    tx_check(8'h16, 8'h08, -1, 0);

    // Illegal address, then zero length.
    send_cmd(2'd3, 6'd5, 1'b0);
    chk("illegal_addr_cmd_err", cmd_err, 8'h01);
    chk("illegal_addr_pl_ready", pl_ready, 8'h00);
    chk("illegal_addr_pkt_valid", pkt_valid, 8'h00);
    chk("illegal_addr_cmd_ready", cmd_ready, 8'h01);
    tick();
    chk("illegal_addr_err_clears", cmd_err, 8'h00);
    send_cmd(2'd1, 6'd0, 1'b0);
    chk("zero_len_cmd_err", cmd_err, 8'h01);
    chk("zero_len_pl_ready", pl_ready, 8'h00);
    chk("zero_len_pkt_valid", pkt_valid, 8'h00);
    tick();
    chk("zero_len_err_clears", cmd_err, 8'h00);
    chk("zero_len_cmd_ready", cmd_ready, 8'h01);

    // len 1 with a 2-cycle payload gap: header 05, parity 5F.
    send_cmd(2'd1, 6'd1, 1'b0);
    tick();
    tick();
    chk("gap_pl_ready_held", pl_ready, 8'h01);
    chk("gap_pkt_valid_low", pkt_valid, 8'h00);
    chk("gap_data_out_zero", data_out, 8'h00);
    pay = '{8'h5A};
    load_payload();
    tx_check(8'h05, 8'h5F, -1, 0);

    // Back-to-back: addr 0 len 2 -> header 08, parity 08^11^22 = 3B.
    pay = '{8'h11, 8'h22};
    send_cmd(2'd0, 6'd2, 1'b0);
    load_payload();
    tx_check(8'h08, 8'h3B, -1, 0);

    // Reset while in PAYLOAD.
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_cmd(2'd2, 6'd5, 1'b0);
    load_payload();
    chk("pre_reset_header", data_out, 8'h16);
    tick();
    tick();
    chk("pre_reset_payload", data_out, 8'hB2);
    reset = 1'b1;
    tick();
    chk("mid_reset_pkt_valid", pkt_valid, 8'h00);
    chk("mid_reset_data_out", data_out, 8'h00);
    chk("mid_reset_cmd_ready", cmd_ready, 8'h01);
    chk("mid_reset_done", done, 8'h00);
    chk("mid_reset_cmd_err", cmd_err, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_pkt_valid", pkt_valid, 8'h00);
    chk("post_reset_pl_ready", pl_ready, 8'h00);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
